// File: rtl/scan_mux_pkg.sv
// Shared types and helpers for the scanning N-to-1 selector.
package scan_mux_pkg;

   typedef enum logic [1:0] {
      MANUAL,
      SCAN,
      FROZEN
   } state_e;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Out-of-range select codes pick the last channel, matching the legacy switch board.
   function automatic int unsigned sat_sel(input int unsigned s, input int unsigned channels);
      return (s < channels) ? s : channels - 1;
   endfunction

endpackage

// File: rtl/scan_mux_nto1_if.sv
// Channel data, control and registered outputs of the scanning selector.
interface scan_mux_nto1_if #(
   parameter int unsigned WIDTH    = 3,
   parameter int unsigned CHANNELS = 5
);
   localparam int unsigned SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [CHANNELS*WIDTH-1:0] data_in;
   logic                      mode;
   logic [SELW-1:0]           sel_in;
   logic                      freeze;
   logic [WIDTH-1:0]          data_out;
   logic [SELW-1:0]           cur_sel;
   logic                      wrap;

   modport master (
      output data_in, mode, sel_in, freeze,
      input  data_out, cur_sel, wrap
   );

   modport slave (
      input  data_in, mode, sel_in, freeze,
      output data_out, cur_sel, wrap
   );
endinterface

// File: rtl/scan_mux_nto1_mux.sv
// Combinational N-to-1 slice selector with a saturating select.
module mux_nto1
   import scan_mux_pkg::*;
#(
   parameter int unsigned WIDTH    = 3,
   parameter int unsigned CHANNELS = 5,
   parameter int unsigned SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic [CHANNELS*WIDTH-1:0] data_i,
   input  logic [SELW-1:0]           sel_i,
   output logic [WIDTH-1:0]          data_o
);

   int unsigned idx;

   always_comb begin
      idx    = sat_sel(32'(sel_i), CHANNELS);
      data_o = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         if (k == idx) begin
            data_o = data_i[k*WIDTH +: WIDTH];
         end
      end
   end

endmodule

// File: rtl/scan_mux_nto1.sv
// Registered N-channel selector: manual select, timed round-robin scan, freeze.
module scan_mux_nto1
   import scan_mux_pkg::*;
#(
   parameter int unsigned WIDTH    = 3,
   parameter int unsigned CHANNELS = 5,
   parameter int unsigned DWELL    = 4
) (
   input  logic             clk,
   input  logic             reset,
   scan_mux_nto1_if.slave   bus
);

   localparam int unsigned SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int unsigned CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [SELW-1:0] SEL_LAST = SELW'(CHANNELS - 1);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

   state_e            state_q, state_d;
   logic [CNTW-1:0]   cnt_q, cnt_d, cnt_cur;
   logic [SELW-1:0]   sel_q, sel_d;
   logic [WIDTH-1:0]  data_q, data_d, mux_data;
   logic              wrap_q, wrap_d;

   mux_nto1 #(
      .WIDTH    (WIDTH),
      .CHANNELS (CHANNELS),
      .SELW     (SELW)
   ) u_mux (
      .data_i (bus.data_in),
      .sel_i  (sel_d),
      .data_o (mux_data)
   );

   // The action on an edge follows the state being entered, so freeze wins over a dwell expiry.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      wrap_d  = 1'b0;
      cnt_cur = (state_q == MANUAL) ? '0 : cnt_q;

      if (bus.freeze) begin
         state_d = FROZEN;
      end else if (bus.mode == MODE_MANUAL) begin
         state_d = MANUAL;
      end else begin
         state_d = SCAN;
      end

      case (state_d)
         MANUAL: begin
            sel_d = SELW'(sat_sel(32'(bus.sel_in), CHANNELS));
            cnt_d = '0;
         end
         SCAN: begin
            if (cnt_cur == CNT_LAST) begin
               cnt_d = '0;
               if (sel_q == SEL_LAST) begin
                  sel_d  = '0;
                  wrap_d = 1'b1;
               end else begin
                  sel_d = sel_q + SELW'(1);
               end
            end else begin
               cnt_d = cnt_cur + CNTW'(1);
            end
         end
         default: ;
      endcase

      data_d = (state_d == FROZEN) ? data_q : mux_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= MANUAL;
         cnt_q   <= '0;
         sel_q   <= '0;
         data_q  <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         wrap_q  <= wrap_d;
      end
   end

   assign bus.data_out = data_q;
   assign bus.cur_sel  = sel_q;
   assign bus.wrap     = wrap_q;

endmodule
